dma_arbiter: RTL
================

DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST_BYTES, default 256, meaning the largest byte count of one DMA command; power of two, 4..4096.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports reqN_valid_i  input  1  transfer request from requester N (N=0 tile scheduler, N=1 descriptor/writeback engine).
REQ-005 SHALL have ports reqN_read_i  input  1  1=DRAM->GLB, 0=GLB->DRAM; reqN_addr_i  input  32  DRAM byte address; reqN_len_i  input  32  byte length.
REQ-006 SHALL have ports reqN_ready_o  output  1  one-cycle accept pulse; reqN_done_o  output  1  one-cycle completion pulse.
REQ-007 SHALL have ports dma_cmd_valid_o  output  1; dma_cmd_ready_i  input  1; dma_cmd_read_o  output  1; dma_cmd_addr_o  output  32; dma_cmd_len_o  output  32: burst command to DMA engine.
REQ-008 SHALL have port dma_done_i  input  1  one-cycle pulse, the outstanding burst has completed.
REQ-009 SHALL have ports busy_o  output  1  high outside IDLE; grant_o  output  1  index of current owner.

Function
REQ-010 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-011 IDLE: when any reqN_valid_i is high, SHALL select a winner, pulse its reqN_ready_o in that cycle, latch read/addr/len into working registers, set grant_o, and go to ISSUE (or DONE if len==0).
REQ-012 ISSUE: SHALL drive dma_cmd_valid_o=1 with addr=working addr, len=min(remaining, MAX_BURST_BYTES, 4096-addr[11:0]); command fields SHALL stay stable until dma_cmd_ready_i; on handshake go to WAIT.
REQ-013 No burst SHALL cross a 4 KB DRAM address boundary.
REQ-014 WAIT: on dma_done_i, working addr += issued len, remaining -= issued len; remaining==0 -> DONE, else -> ISSUE.
REQ-015 DONE: SHALL pulse reqN_done_o of the owner for exactly one cycle, then return to IDLE; a new request may be granted in the following cycle.
REQ-016 Latency: accept pulse to first dma_cmd_valid_o SHALL be 1 cycle; dma_done_i of last burst to reqN_done_o SHALL be 1 cycle.
REQ-017 dma_done_i outside WAIT SHALL be ignored; dma_cmd_ready_i outside ISSUE SHALL be ignored.
REQ-018 Requests arriving while busy SHALL not be accepted; requesters hold valid and fields until their ready pulse.
REQ-019 Only one command SHALL be outstanding at any time.
REQ-020 Length/address arithmetic SHALL be 32-bit unsigned; address wrap past 0xFFFFFFFF is not detected.

Reset
REQ-021 On rst_n low, state SHALL be IDLE and all outputs 0 (dma_cmd_*, reqN_ready_o, reqN_done_o, busy_o, grant_o), working registers 0, round-robin pointer favouring requester 0.
REQ-022 Reset mid-transfer SHALL abandon the transfer with no done pulse; DMA engine is reset by the same rst_n.

Configuration
REQ-023 With DMA_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: winner is the requester not granted last; pointer updates on each accept.
REQ-024 Without DMA_ARB_RR_EN, requester 0 SHALL always win simultaneous requests (fixed priority); no pointer state exists.

Verification
REQ-025 req0 read addr=0x1000 len=600, ready tied 1 -> three commands (0x1000,256),(0x1100,256),(0x1200,88); req0_done_o one cycle after third dma_done_i.
REQ-026 req1 write addr=0x0FC0 len=200 -> commands (0x0FC0,64),(0x1000,136); no 4 KB crossing.
REQ-027 req0 and req1 valid same cycle, repeated 4 transfers -> with DMA_ARB_RR_EN grants 0,1,0,1; without, grants 0,0,0,0 while req0 stays valid.
REQ-028 dma_cmd_ready_i held 0 for 5 cycles -> dma_cmd_valid_o and fields stable for 5 cycles; dma_done_i pulse during ISSUE ignored.
REQ-029 req0 len=0 -> ready pulse, no dma_cmd_valid_o, done pulse 1 cycle later.
REQ-030 rst_n asserted in WAIT of a 600-byte transfer -> all outputs 0 immediately, no done pulse; next request processed normally.

Source files
------------

// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_arbiter
// Purpose  : Arbitrates two DMA requesters and splits each accepted transfer
//            into bursts of at most MAX_BURST_BYTES that never cross a 4 KB
//            DRAM page. Define DMA_ARB_RR_EN for round-robin arbitration;
//            otherwise requester 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================

module dma_arbiter #(
    parameter int unsigned MAX_BURST_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid_i,
    input  logic        req0_read_i,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_len_i,
    output logic        req0_ready_o,
    output logic        req0_done_o,

    input  logic        req1_valid_i,
    input  logic        req1_read_i,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_len_i,
    output logic        req1_ready_o,
    output logic        req1_done_o,

    output logic        dma_cmd_valid_o,
    input  logic        dma_cmd_ready_i,
    output logic        dma_cmd_read_o,
    output logic [31:0] dma_cmd_addr_o,
    output logic [31:0] dma_cmd_len_o,
    input  logic        dma_done_i,

    output logic        busy_o,
    output logic        grant_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] MAX_LEN = MAX_BURST_BYTES;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rem_q, rem_d;
    logic        read_q, read_d;
    logic        grant_q, grant_d;

    logic        any_valid;
    logic        win;
    logic        accept;
    logic        sel_read;
    logic [31:0] sel_addr;
    logic [31:0] sel_len;
    logic [12:0] page_left;
    logic [31:0] burst_len;
    logic        issue;

    assign any_valid = req0_valid_i | req1_valid_i;

`ifdef DMA_ARB_RR_EN
    // rr_q names the requester favoured on a tie: the one not granted last.
    logic rr_q, rr_d;
    assign win = (req0_valid_i && req1_valid_i) ? rr_q : req1_valid_i;
`else
    assign win = ~req0_valid_i;
`endif

    assign sel_read = win ? req1_read_i : req0_read_i;
    assign sel_addr = win ? req1_addr_i : req0_addr_i;
    assign sel_len  = win ? req1_len_i  : req0_len_i;

    // Burst = min(remaining, MAX_BURST_BYTES, bytes left in this 4 KB page).
    assign page_left = 13'd4096 - {1'b0, addr_q[11:0]};

    always_comb begin
        burst_len = rem_q;
        if (burst_len > MAX_LEN) begin
            burst_len = MAX_LEN;
        end
        if (burst_len > {19'd0, page_left}) begin
            burst_len = {19'd0, page_left};
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        read_d  = read_q;
        grant_d = grant_q;
        accept  = 1'b0;
`ifdef DMA_ARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_valid && rst_n) begin
                    accept  = 1'b1;
                    grant_d = win;
                    read_d  = sel_read;
                    addr_d  = sel_addr;
                    rem_d   = sel_len;
`ifdef DMA_ARB_RR_EN
                    rr_d    = ~win;
`endif
                    state_d = (sel_len == 32'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (dma_cmd_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dma_done_i) begin
                    addr_d  = addr_q + burst_len;
                    rem_d   = rem_q - burst_len;
                    state_d = (rem_q == burst_len) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            rem_q   <= 32'd0;
            read_q  <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            read_q  <= read_d;
            grant_q <= grant_d;
        end
    end

`ifdef DMA_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Working registers are frozen in ISSUE, so the command stays stable.
    assign issue           = (state_q == S_ISSUE);
    assign dma_cmd_valid_o = issue;
    assign dma_cmd_read_o  = issue & read_q;
    assign dma_cmd_addr_o  = issue ? addr_q : 32'd0;
    assign dma_cmd_len_o   = issue ? burst_len : 32'd0;

    assign req0_ready_o = accept & ~win;
    assign req1_ready_o = accept &  win;
    assign req0_done_o  = (state_q == S_DONE) & ~grant_q;
    assign req1_done_o  = (state_q == S_DONE) &  grant_q;

    assign busy_o  = (state_q != S_IDLE);
    assign grant_o = grant_q;

endmodule

`default_nettype wire
